// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared definitions for the mac_stream engine.
//                - state_t : FSM state encoding (IDLE/RUN/DRAIN/DONE)
//                - CNT_W   : width of the accepted-pair counter
//                - sat_max / sat_min : accumulator saturation limits, returned
//                  as 64-bit values; callers keep the low ACC_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest representable accumulator value: all ones (unsigned) or
  // 0111..1 (signed). Valid for 2 <= acc_w <= 64.
  function automatic logic [63:0] sat_max(input int acc_w, input int signed_mode);
    logic [63:0] ones;
    ones = '1;
    if (signed_mode != 0) begin
      return ones >> (65 - acc_w);
    end
    return ones >> (64 - acc_w);
  endfunction

  // Smallest representable accumulator value: zero (unsigned) or 1000..0
  // (signed); the bits above acc_w are don't-care for the caller.
  function automatic logic [63:0] sat_min(input int acc_w, input int signed_mode);
    logic [63:0] ones;
    ones = '1;
    if (signed_mode != 0) begin
      return ~(ones >> (65 - acc_w));
    end
    return 64'd0;
  endfunction

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_acc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mac_acc_unit
//  Description : Combinational accumulate step. Extends the 2*DATA_W product
//                to ACC_W bits (sign or zero), adds it to the current
//                accumulator and, when MAC_STREAM_SAT_EN is defined, clamps the
//                sum to the representable range and flags the clamp.
//                Without MAC_STREAM_SAT_EN the sum wraps modulo 2^ACC_W and
//                ovf_pulse is constant 0.
//  Ports       : acc       in  ACC_W     current accumulator value
//                prod      in  2*DATA_W  registered product
//                acc_next  out ACC_W     accumulator value after the add
//                ovf_pulse out 1         saturation happened on this add
//  Macro       : MAC_STREAM_SAT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_acc_unit
  import mac_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 12,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0]    acc,
  input  logic [2*DATA_W-1:0] prod,
  output logic [ACC_W-1:0]    acc_next,
  output logic                ovf_pulse
);

  localparam int P_W = 2 * DATA_W;

  logic [ACC_W-1:0] w_p_ext;

  generate
    if (ACC_W > P_W) begin : g_ext_wide
      logic w_fill;
      assign w_fill  = (SIGNED != 0) ? prod[P_W-1] : 1'b0;
      assign w_p_ext = {{(ACC_W - P_W){w_fill}}, prod};
    end else begin : g_ext_same
      assign w_p_ext = prod;
    end
  endgenerate

`ifdef MAC_STREAM_SAT_EN
  localparam logic [ACC_W-1:0] c_max = ACC_W'(sat_max(ACC_W, SIGNED));
  localparam logic [ACC_W-1:0] c_min = ACC_W'(sat_min(ACC_W, SIGNED));

  logic             w_acc_sx;
  logic             w_p_sx;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf;
  logic             w_neg;

  // One guard bit: for signed data it carries the true sign, for unsigned
  // data it is the carry out.
  assign w_acc_sx = (SIGNED != 0) ? acc[ACC_W-1]     : 1'b0;
  assign w_p_sx   = (SIGNED != 0) ? w_p_ext[ACC_W-1] : 1'b0;
  assign w_sum    = {w_acc_sx, acc} + {w_p_sx, w_p_ext};

  // Signed overflow: guard bit disagrees with the result sign. Unsigned
  // products are never negative, so only the upper limit can be crossed.
  assign w_ovf = (SIGNED != 0) ? (w_sum[ACC_W] != w_sum[ACC_W-1]) : w_sum[ACC_W];
  assign w_neg = (SIGNED != 0) && w_sum[ACC_W];

  always_comb begin
    acc_next  = w_sum[ACC_W-1:0];
    ovf_pulse = 1'b0;
    if (w_ovf) begin
      ovf_pulse = 1'b1;
      acc_next  = w_neg ? c_min : c_max;
    end
  end
`else
  assign acc_next  = acc + w_p_ext;
  assign ovf_pulse = 1'b0;
`endif

endmodule : mac_acc_unit
`default_nettype wire

// File: rtl/mac_stream.sv
`default_nettype none
// ============================================================================
//  Module      : mac_stream
//  Description : Pipelined multiply-accumulate engine. After start it accepts
//                LEN operand pairs over a valid/ready handshake, multiplies
//                each pair into a product register (stage 1), adds the
//                product into the accumulator one edge later (stage 2), then
//                drains for two cycles and offers the dot product on a
//                valid/ready output handshake.
//  Ports       : clk, rst           clock, asynchronous active-high reset
//                start, clear       begin run (IDLE only) / synchronous abort
//                in_valid, in_ready operand handshake, a/b operands
//                out_valid, out_ready, out  result handshake and value
//                busy               high in RUN, DRAIN, DONE
//                cnt                pairs accepted in the current run
//                ovf                sticky saturation flag
//  Macro       : MAC_STREAM_SAT_EN enables saturating accumulation and ovf;
//                when undefined the sum wraps and ovf stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_stream
  import mac_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 12,
  parameter int LEN    = 10,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt,
  output logic              ovf
);

  localparam int              P_W   = 2 * DATA_W;
  localparam logic [CNT_W-1:0] c_len = CNT_W'(LEN);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [P_W-1:0]     r_p_q;
  logic               r_p_vld;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_out;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_drain_ph;

  logic               w_accept;
  logic               w_last;
  logic               w_a_fill;
  logic               w_b_fill;
  logic [P_W-1:0]     w_a_ext;
  logic [P_W-1:0]     w_b_ext;
  logic [P_W-1:0]     w_prod;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_ovf_pulse;

  // Operands are widened to the product width first; the low P_W bits of the
  // widened product equal the exact signed or unsigned product.
  assign w_a_fill = (SIGNED != 0) ? a[DATA_W-1] : 1'b0;
  assign w_b_fill = (SIGNED != 0) ? b[DATA_W-1] : 1'b0;
  assign w_a_ext  = {{DATA_W{w_a_fill}}, a};
  assign w_b_ext  = {{DATA_W{w_b_fill}}, b};
  assign w_prod   = w_a_ext * w_b_ext;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == (c_len - 16'd1));

  mac_acc_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_acc_unit (
    .acc       (r_acc),
    .prod      (r_p_q),
    .acc_next  (w_acc_next),
    .ovf_pulse (w_ovf_pulse)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        in_ready = (r_cnt < c_len);
        if (w_accept && w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain_ph) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (clear) w_state_nxt = ST_IDLE;
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_q      <= '0;
      r_p_vld    <= 1'b0;
      r_acc      <= '0;
      r_out      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_drain_ph <= 1'b0;
    end else if (clear) begin
      // out is deliberately left alone so the last result stays visible.
      r_p_vld    <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_drain_ph <= 1'b0;
    end else begin
      r_p_vld <= w_accept;
      if (w_accept) begin
        r_p_q <= w_prod;
        r_cnt <= r_cnt + 16'd1;
      end

      if ((r_state == ST_IDLE) && start) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (r_p_vld) begin
        r_acc <= w_acc_next;
        if (w_ovf_pulse) r_ovf <= 1'b1;
      end

      // First DRAIN cycle absorbs the last product, second publishes it.
      if (r_state == ST_DRAIN) begin
        r_drain_ph <= ~r_drain_ph;
        if (r_drain_ph) r_out <= r_acc;
      end else begin
        r_drain_ph <= 1'b0;
      end
    end
  end

  assign out = r_out;
  assign cnt = r_cnt;
  assign ovf = r_ovf;

endmodule : mac_stream
`default_nettype wire

// File: tb/tb_mac_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_stream
//  Description : Directed self-checking bench for mac_stream. Three instances:
//                default (unsigned 4x4 -> 12, LEN=10), signed (SIGNED=1) and
//                narrow (ACC_W=8, LEN=2) for wrap / saturation behaviour.
//  Macro       : MAC_STREAM_SAT_EN selects the narrow-instance expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_stream;

  logic clk;
  logic rst;

  int n_cmp;
  int n_fail;

`ifdef MAC_STREAM_SAT_EN
  localparam int M_EXP_OUT = 255;
  localparam int M_EXP_OVF = 1;
`else
  localparam int M_EXP_OUT = 194;
  localparam int M_EXP_OVF = 0;
`endif

  // default instance
  logic        d_start, d_clear, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy, d_ovf;
  logic [3:0]  d_a, d_b;
  logic [11:0] d_out;
  logic [15:0] d_cnt;
  // signed instance
  logic        s_start, s_clear, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy, s_ovf;
  logic [3:0]  s_a, s_b;
  logic [11:0] s_out;
  logic [15:0] s_cnt;
  // narrow instance
  logic        m_start, m_clear, m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_busy, m_ovf;
  logic [3:0]  m_a, m_b;
  logic [7:0]  m_out;
  logic [15:0] m_cnt;

  mac_stream u_dut (
    .clk(clk), .rst(rst), .start(d_start), .clear(d_clear),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out(d_out),
    .busy(d_busy), .cnt(d_cnt), .ovf(d_ovf)
  );

  mac_stream #(.DATA_W(4), .ACC_W(12), .LEN(10), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .start(s_start), .clear(s_clear),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out),
    .busy(s_busy), .cnt(s_cnt), .ovf(s_ovf)
  );

  mac_stream #(.DATA_W(4), .ACC_W(8), .LEN(2), .SIGNED(0)) u_sm (
    .clk(clk), .rst(rst), .start(m_start), .clear(m_clear),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .a(m_a), .b(m_b),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out(m_out),
    .busy(m_busy), .cnt(m_cnt), .ovf(m_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    d_start = 0; d_clear = 0; d_in_valid = 0; d_out_ready = 0; d_a = 0; d_b = 0;
    s_start = 0; s_clear = 0; s_in_valid = 0; s_out_ready = 1; s_a = 0; s_b = 0;
    m_start = 0; m_clear = 0; m_in_valid = 0; m_out_ready = 0; m_a = 0; m_b = 0;

    // ---------------- reset state ----------------
    #3;
    check("rst_out",       d_out,       0);
    check("rst_out_valid", d_out_valid, 0);
    check("rst_in_ready",  d_in_ready,  0);
    check("rst_busy",      d_busy,      0);
    check("rst_cnt",       d_cnt,       0);
    check("rst_ovf",       d_ovf,       0);
    tick();
    rst = 1'b0;

    // ---------------- 10 x (3*4) back-to-back ----------------
    d_start = 1; tick(); d_start = 0;
    check("run_busy",     d_busy,     1);
    check("run_in_ready", d_in_ready, 1);
    check("run_cnt0",     d_cnt,      0);
    d_a = 4'd3; d_b = 4'd4; d_in_valid = 1;
    repeat (9) tick();
    check("run_cnt9",      d_cnt,      9);
    check("run_in_ready9", d_in_ready, 1);
    tick();                                   // edge E: 10th pair accepted
    d_in_valid = 0;
    check("run_cnt10",     d_cnt,       10);
    check("drain_in_rdy",  d_in_ready,  0);
    check("drain_ov_e0",   d_out_valid, 0);
    tick();                                   // E+1
    check("drain_ov_e1",   d_out_valid, 0);
    tick();                                   // E+2
    check("done_ov",       d_out_valid, 1);
    check("done_out120",   d_out,       120);
    check("done_cnt",      d_cnt,       10);

    // ---------------- backpressure, start and in_valid ignored in DONE ----
    d_in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      d_start = (i == 2);
      tick();
      check("bp_ov",   d_out_valid, 1);
      check("bp_out",  d_out,       120);
      check("bp_busy", d_busy,      1);
    end
    d_start = 0; d_in_valid = 0;
    check("bp_cnt", d_cnt, 10);
    d_out_ready = 1; tick(); d_out_ready = 0;
    check("acc_ov",   d_out_valid, 0);
    check("acc_busy", d_busy,      0);
    check("acc_out",  d_out,       120);
    tick();
    check("idle_stays", d_busy, 0);

    // ---------------- async reset mid-run ----------------
    d_start = 1; tick(); d_start = 0;
    d_a = 4'd5; d_b = 4'd5; d_in_valid = 1;
    repeat (4) tick();
    check("mid_cnt4", d_cnt, 4);
    #2 rst = 1'b1;
    #1;
    check("arst_out",       d_out,       0);
    check("arst_cnt",       d_cnt,       0);
    check("arst_busy",      d_busy,      0);
    check("arst_in_ready",  d_in_ready,  0);
    check("arst_out_valid", d_out_valid, 0);
    #2 rst = 1'b0;
    d_a = 4'd1; d_b = 4'd2;                   // in_valid still high while IDLE
    tick(); tick();
    check("idle_iv_cnt",  d_cnt,  0);
    check("idle_iv_busy", d_busy, 0);
    d_start = 1; tick(); d_start = 0;
    check("r2_cnt0",  d_cnt,      0);
    check("r2_ready", d_in_ready, 1);
    repeat (10) tick();
    d_in_valid = 0;
    check("r2_cnt10", d_cnt, 10);
    tick(); tick();
    check("r2_ov",    d_out_valid, 1);
    check("r2_out20", d_out,       20);
    d_out_ready = 1; tick(); d_out_ready = 0;

    // ---------------- clear + start mid-run ----------------
    d_start = 1; tick(); d_start = 0;
    d_a = 4'd2; d_b = 4'd3; d_in_valid = 1;
    repeat (3) tick();
    check("clr_pre_cnt", d_cnt, 3);
    d_clear = 1; d_start = 1;
    tick();
    d_clear = 0; d_start = 0; d_in_valid = 0;
    check("clr_busy",     d_busy,      0);
    check("clr_cnt",      d_cnt,       0);
    check("clr_ov",       d_out_valid, 0);
    check("clr_in_ready", d_in_ready,  0);
    check("clr_out_kept", d_out,       20);
    tick();
    check("clr_idle", d_busy, 0);
    d_start = 1; tick(); d_start = 0;
    d_in_valid = 1;
    repeat (10) tick();
    d_in_valid = 0;
    tick(); tick();
    check("clr_run_ov",   d_out_valid, 1);
    check("clr_run_out",  d_out,       60);
    d_out_ready = 1; tick(); d_out_ready = 0;

    // ---------------- signed, in_valid every other cycle ----------------
    s_start = 1; tick(); s_start = 0;
    s_a = 4'h8; s_b = 4'd7;                   // -8 * 7 = -56
    for (int k = 0; k < 9; k++) begin
      s_in_valid = 1; tick(); s_in_valid = 0;
      if (k == 4) begin
        check("sgn_cnt5",   s_cnt,      5);
        check("sgn_ready5", s_in_ready, 1);
      end
      tick();
    end
    s_in_valid = 1; tick(); s_in_valid = 0;   // edge E
    check("sgn_cnt10",  s_cnt,       10);
    check("sgn_ready0", s_in_ready,  0);
    tick();
    check("sgn_ov_e1",  s_out_valid, 0);
    tick();
    check("sgn_ov",     s_out_valid, 1);
    check("sgn_out",    s_out,       12'hDD0);
    tick();
    check("sgn_idle_ov",   s_out_valid, 0);
    check("sgn_idle_busy", s_busy,      0);

    // ---------------- narrow accumulator: 15*15 twice ----------------
    m_start = 1; tick(); m_start = 0;
    m_a = 4'd15; m_b = 4'd15; m_in_valid = 1;
    tick();
    check("sm_cnt1",   m_cnt,      1);
    check("sm_ready1", m_in_ready, 1);
    tick();
    m_in_valid = 0;
    check("sm_cnt2",   m_cnt,      2);
    check("sm_ready0", m_in_ready, 0);
    tick(); tick();
    check("sm_ov",  m_out_valid, 1);
    check("sm_out", m_out,       M_EXP_OUT);
    check("sm_ovf", m_ovf,       M_EXP_OVF);
    m_out_ready = 1; tick(); m_out_ready = 0;
    check("sm_ovf_sticky", m_ovf, M_EXP_OVF);
    m_start = 1; tick(); m_start = 0;
    check("sm_ovf_start", m_ovf, 0);
    m_a = 4'd1; m_b = 4'd1; m_in_valid = 1;
    tick(); tick();
    m_in_valid = 0;
    tick(); tick();
    check("sm2_ov",  m_out_valid, 1);
    check("sm2_out", m_out,       2);
    check("sm2_ovf", m_ovf,       0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mac_stream
`default_nettype wire

// File: doc/mac_stream.md
Name: mac_stream

Overview:
- Parametrised, pipelined multiply-accumulate engine; successor to the fixed 4-bit / 10-term MAC datapath.
- Consumes a stream of LEN operand pairs over a valid/ready handshake and accumulates their products.
- Presents the dot-product result over a second valid/ready handshake.
- Sits between the operand sequencer and the result collector; supports signed or unsigned operands.

Parameters:
DATA_W, 4, operand width in bits (A and B)
ACC_W, 12, accumulator and result width; must be >= 2*DATA_W
LEN, 10, number of operand pairs per accumulation; range 1..2^16-1
SIGNED, 0, 0 = unsigned operands and result; 1 = two's-complement operands and result

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin new accumulation; honoured only in IDLE
clear  input  1  synchronous abort: return to IDLE, zero accumulator; ignored during rst
in_valid  input  1  operand pair a/b valid
in_ready  output  1  engine can accept a pair this cycle
a  input  DATA_W  operand A
b  input  DATA_W  operand B
out_valid  output  1  result valid, held until accepted
out_ready  input  1  downstream accepts result
out  output  ACC_W  accumulated result
busy  output  1  high in RUN, DRAIN and DONE
cnt  output  16  pairs accepted in the current run
ovf  output  1  sticky overflow flag; see Optional Feature

Behaviour:
- Reset (async, any state including mid-run): state=IDLE; accumulator, product reg, out, cnt, ovf all 0; out_valid, in_ready, busy all 0.
- IDLE:
  - start=1 -> RUN next edge; accumulator, cnt and ovf zeroed on the same edge.
  - Outputs out and out_valid: out retains its last value; out_valid=0.
- RUN:
  - in_ready=1 while cnt < LEN.
  - A pair is accepted on an edge where in_valid&&in_ready.
  - On acceptance: p_q <= a*b (full 2*DATA_W product, sign-extended when SIGNED=1); product-valid bit set; cnt increments.
  - Pipeline stage 2: on the edge after each product lands, accumulator <= accumulator + extend(p_q) to ACC_W.
  - Gaps in in_valid insert bubbles; no accumulation occurs for bubbles.
  - Exit: the edge that accepts pair LEN moves the FSM to DRAIN; in_ready=0 from the next cycle.
- DRAIN: lasts exactly 2 cycles (accumulator update for the last product, then out <= accumulator), then DONE.
- DONE:
  - out_valid=1 and out stable.
  - out_valid&&out_ready on an edge -> IDLE, out_valid=0.
  - start asserted in DONE is ignored.
- Latency: last pair accepted on edge E -> out_valid high after edge E+2 (first observable in the cycle following E+2).
- clear:
  - Any state -> IDLE next edge: accumulator=0, cnt=0, pipeline valid bits=0, out_valid=0, ovf=0. out keeps its old value.
  - clear has priority over start and over all handshakes in the same cycle.
- Arithmetic: products and sums are modulo 2^ACC_W (wrap), unless SAT_EN is defined.
- Boundary cases:
  - LEN=1: RUN lasts until a single acceptance, then DRAIN.
  - cnt never exceeds LEN.
  - in_valid asserted in IDLE, DRAIN or DONE has no effect.

Optional Feature:
- Macro: MAC_STREAM_SAT_EN.
- Defined:
  - Accumulator saturates at its max (2^ACC_W-1 unsigned; 2^(ACC_W-1)-1 signed) or its min (0 unsigned; -2^(ACC_W-1) signed).
  - ovf is set on the edge any saturation occurs and stays set until start, clear or rst.
- Undefined: wrap-around arithmetic; ovf tied 0.

Decomposition:
- Package mac_pkg holds:
  - FSM state encoding IDLE/RUN/DRAIN/DONE.
  - Counter width constant CNT_W=16.
  - Functions sat_max(ACC_W, SIGNED) and sat_min(ACC_W, SIGNED).
- One sub-module, mac_acc_unit: extends the product, adds it to the accumulator, applies optional saturation, and reports the overflow pulse. Purely combinational add/sat, with the accumulator register in the parent.

Test Plan:
- Defaults; start; 10 pairs a=3, b=4 back-to-back -> out=120 (0x078), out_valid 2 edges after the 10th acceptance, cnt=10.
- SIGNED=1; 10 pairs a=-8, b=7 with in_valid toggling every other cycle -> out=0xDD0 (-560); in_ready low after the 10th pair.
- DATA_W=4, ACC_W=8, LEN=2; pairs 15*15 twice -> without MAC_STREAM_SAT_EN out=194, ovf=0; with it out=255, ovf=1.
- Result backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid and out stable; start pulsed during DONE is ignored; out_ready=1 -> IDLE.
- rst asserted after 4 of 10 pairs (a=5, b=5) -> all outputs 0 immediately. Then a full new run of 10 pairs a=1, b=2 -> out=20.
- clear and start in the same cycle mid-RUN -> IDLE, cnt=0, out_valid=0; a subsequent start runs normally.
